// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//  - ld_state_t    : loader FSM state encoding
//  - BYTES_PER_WORD: stream bytes packed into one instruction word
//  - DEFAULT_*     : default RAM address width and idle timeout
//  - clamp_len     : maps the LEN byte onto an effective word count
package inst_mem_loader_pkg;

  localparam int BYTES_PER_WORD  = 4;
  localparam int DEFAULT_ADDR_W  = 6;
  localparam int DEFAULT_TIMEOUT = 1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5
  } ld_state_t;

  // LEN of 0 means "fill the whole RAM"; anything larger than the RAM is
  // clamped so the word address can never wrap.
  function automatic int clamp_len(input logic [7:0] n, input int max_words);
    if (n == 8'd0 || int'(n) > max_words) return max_words;
    return int'(n);
  endfunction

endpackage

// File: rtl/inst_mem_loader_timeout.sv
// Loadable down-counter used as an inter-byte idle watchdog.
// Ports:
//  clk, rst  : clock, asynchronous active-high reset
//  load      : reload the counter to TIMEOUT (an accepted byte / new load)
//  en        : count this cycle (loader waiting for a byte)
//  expired   : high in the TIMEOUT-th consecutive idle counted cycle
module loader_timeout_cnt #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_W'(TIMEOUT);
    end else if (load) begin
      cnt <= CNT_W'(TIMEOUT);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // cnt==1 while counting means TIMEOUT-1 idle cycles already elapsed, so
  // this cycle is the TIMEOUT-th one; the FSM aborts on the coming edge.
  assign expired = en & ~load & (cnt == CNT_W'(1));

endmodule

// File: rtl/inst_mem_loader.sv
// Writer side of the instruction RAM. Packs a byte stream
// (LEN, 4*N data bytes MSB first, XOR checksum) into 32-bit words and writes
// them to consecutive word addresses, holding the fetch logic in reset while
// a load is in progress.
// Ports:
//  clk, rst    : clock, asynchronous active-high reset
//  start       : 1-cycle pulse starting a load (ignored unless idle)
//  byte_in     : stream byte, qualified by byte_valid
//  byte_ready  : loader accepts a byte this cycle
//  mem_we      : 1-cycle RAM write strobe per packed word
//  mem_addr    : RAM word address of the current write
//  mem_wdata   : packed instruction word
//  busy        : load in progress
//  done, err   : load finished / checksum or timeout error; held until start
//  cpu_rst     : reset for fetch/PC logic (rst or busy)
//  word_cnt    : words written in the current/last load
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int MAX_WORDS = 2 ** ADDR_W;

  ld_state_t       state, state_nx;
  logic [ADDR_W:0] n_words;
  logic [7:0]      csum;
  logic [1:0]      byte_idx;
  logic            accept;
  logic            last_byte;
  logic            last_word;
  logic            tmo_load;
  logic            tmo_en;
  logic            tmo_expired;

  assign accept    = byte_valid & byte_ready;
  assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));
  assign last_word = ((word_cnt + 1'b1) == n_words);
  assign cpu_rst   = rst | busy;

  assign tmo_load = accept | ((state == ST_IDLE) & start);
  assign tmo_en   = byte_ready;

  loader_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .load    (tmo_load),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Output decode depends on state only, so byte_ready never loops back
  // through accept/timeout into itself.
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    mem_we     = 1'b0;
    case (state)
      ST_LEN, ST_DATA, ST_CSUM: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      ST_WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_LEN;
      ST_LEN: begin
        if (tmo_expired) state_nx = ST_IDLE;
        else if (accept) state_nx = ST_DATA;
      end
      ST_DATA: begin
        if (tmo_expired)            state_nx = ST_IDLE;
        else if (accept && last_byte) state_nx = ST_WRITE;
      end
      ST_WRITE: state_nx = last_word ? ST_CSUM : ST_DATA;
      ST_CSUM: begin
        if (tmo_expired) state_nx = ST_IDLE;
        else if (accept) state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_words   <= '0;
      csum      <= '0;
      byte_idx  <= '0;
      mem_wdata <= '0;
      mem_addr  <= '0;
      word_cnt  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Timeout abort: already-written words stay in RAM.
      if (tmo_expired) begin
        err  <= 1'b1;
        done <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
            csum     <= '0;
            byte_idx <= '0;
            mem_addr <= '0;
          end
        end
        ST_LEN: begin
          if (accept) n_words <= (ADDR_W + 1)'(clamp_len(byte_in, MAX_WORDS));
        end
        ST_DATA: begin
          if (accept) begin
            mem_wdata <= {mem_wdata[23:0], byte_in};
            csum      <= csum ^ byte_in;
            byte_idx  <= byte_idx + 1'b1;
          end
        end
        ST_WRITE: begin
          word_cnt <= word_cnt + 1'b1;
          // Address holds on the final word so it never wraps past the top.
          if (!last_word) mem_addr <= mem_addr + 1'b1;
        end
        ST_CSUM: begin
          if (accept) begin
            err  <= (byte_in != csum);
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  localparam int AW = 6;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic          cpu_rst;
  logic [AW:0]   word_cnt;

  always #5 clk = ~clk;

  inst_mem_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_rst    (cpu_rst),
    .word_cnt   (word_cnt)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] dut_ram [0:63];
  logic [7:0]  data_b  [0:255];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: effective word count and checksum straight from the frame rules.
  function automatic int eff_len(input int n);
    if (n == 0 || n > 64) return 64;
    return n;
  endfunction

  function automatic logic [7:0] csum_of(input int nbytes);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < nbytes; i++) c = c ^ data_b[i];
    return c;
  endfunction

  // Per-cycle compare: every RAM write must match the next expected word,
  // the stream must be stalled during it, and fetch reset must track busy.
  always @(negedge clk) begin
    if (!rst) begin
      chk("cpu_rst_tracks_busy", {31'd0, cpu_rst}, {31'd0, busy});
      if (mem_we) begin
        chk("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", {26'd0, mem_addr}, mon_e.addr);
          chk("wr_data", mem_wdata, mon_e.data);
        end
        dut_ram[mem_addr] = mem_wdata;
      end
    end
  end

  task automatic clear_ram();
    for (int i = 0; i < 64; i++) dut_ram[i] = 32'hDEAD_BEEF;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Returns at the negedge before the edge that accepts the byte.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 300) begin
      @(negedge clk);
      byte_in    = b;
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc        = byte_valid && byte_ready;
      guard++;
    end
    if (!acc) chk("byte_accept_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int bound, output int k);
    k = 0;
    @(negedge clk);
    byte_valid = 1'b0;
    while (!done && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_wait", 32'd0, 32'd1);
  endtask

  // Queues the writes the model predicts, then drives LEN and ndata bytes.
  // mid_start >= 0 injects a start pulse before that data byte.
  task automatic begin_frame(input int len_byte, input int ndata, input bit rnd,
                             input int mid_start);
    int  n;
    wr_t e;
    n = eff_len(len_byte);
    for (int w = 0; w < n; w++) begin
      if (4 * w + 3 < ndata) begin
        e.addr = w;
        e.data = {data_b[4*w], data_b[4*w+1], data_b[4*w+2], data_b[4*w+3]};
        exp_q.push_back(e);
      end
    end
    pulse_start();
    send_byte(8'(len_byte), rnd);
    for (int i = 0; i < ndata; i++) begin
      if (i == mid_start) pulse_start();
      send_byte(data_b[i], rnd);
    end
  endtask

  task automatic end_checks(input string tag, input logic exp_err, input int exp_words);
    chk({tag, "_done"},     {31'd0, done},     32'd1);
    chk({tag, "_err"},      {31'd0, err},      {31'd0, exp_err});
    chk({tag, "_word_cnt"}, {25'd0, word_cnt}, exp_words);
    chk({tag, "_busy"},     {31'd0, busy},     32'd0);
    chk({tag, "_cpu_rst"},  {31'd0, cpu_rst},  32'd0);
    chk({tag, "_pending"},  exp_q.size(),      32'd0);
  endtask

  task automatic load_t1_bytes();
    logic [63:0] v;
    v = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 8; i++) data_b[i] = v[63-8*i -: 8];
  endtask

  initial begin
    int k;
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    clear_ram();
    repeat (3) @(negedge clk);

    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_mem_we",     {31'd0, mem_we},     32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_done",       {31'd0, done},       32'd0);
    chk("rst_err",        {31'd0, err},        32'd0);
    chk("rst_mem_addr",   {26'd0, mem_addr},   32'd0);
    chk("rst_mem_wdata",  mem_wdata,           32'd0);
    chk("rst_word_cnt",   {25'd0, word_cnt},   32'd0);
    chk("rst_cpu_rst",    {31'd0, cpu_rst},    32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_byte_ready", {31'd0, byte_ready}, 32'd0);

    // 1: good frame, XOR of the eight bytes is 0x00.
    load_t1_bytes();
    chk("t1_model_csum", {24'd0, csum_of(8)}, 32'h00);
    begin_frame(2, 8, 1'b0, -1);
    chk("t1_cpu_rst_in_load", {31'd0, cpu_rst}, 32'd1);
    send_byte(csum_of(8), 1'b0);
    wait_done(20, k);
    end_checks("t1", 1'b0, 2);
    chk("t1_ram0", dut_ram[0], 32'h1234_5678);
    chk("t1_ram1", dut_ram[1], 32'h9ABC_DEF0);

    // 2: same data, wrong checksum byte 0x08.
    clear_ram();
    begin_frame(2, 8, 1'b0, -1);
    send_byte(8'h08, 1'b0);
    wait_done(20, k);
    end_checks("t2", 1'b1, 2);
    chk("t2_ram1", dut_ram[1], 32'h9ABC_DEF0);

    // 3: N=3 with randomly gapped byte_valid.
    clear_ram();
    for (int i = 0; i < 12; i++) data_b[i] = 8'(8'h3C + 8'(i * 29));
    begin_frame(3, 12, 1'b1, -1);
    send_byte(csum_of(12), 1'b1);
    wait_done(400, k);
    end_checks("t3", 1'b0, 3);

    // 4: stall after the 5th data byte until the watchdog aborts.
    clear_ram();
    load_t1_bytes();
    begin_frame(2, 5, 1'b0, -1);
    wait_done(TO + 20, k);
    chk("t4_done",     {31'd0, done},       32'd1);
    chk("t4_err",      {31'd0, err},        32'd1);
    chk("t4_word_cnt", {25'd0, word_cnt},   32'd1);
    chk("t4_idle_gap_in_range", {31'd0, (k >= TO - 1 && k <= TO + 1)}, 32'd1);
    chk("t4_ram0",     dut_ram[0],          32'h1234_5678);
    chk("t4_ram1_untouched", dut_ram[1],    32'hDEAD_BEEF);
    chk("t4_pending",  exp_q.size(),        32'd0);
    @(negedge clk);
    chk("t4_idle_busy",  {31'd0, busy},       32'd0);
    chk("t4_idle_ready", {31'd0, byte_ready}, 32'd0);
    begin_frame(2, 8, 1'b0, -1);
    send_byte(csum_of(8), 1'b0);
    wait_done(20, k);
    end_checks("t4_reload", 1'b0, 2);
    chk("t4_reload_ram1", dut_ram[1], 32'h9ABC_DEF0);

    // 5: reset after 6 data bytes, then a stray start during a second load.
    begin_frame(2, 6, 1'b0, -1);
    @(negedge clk);
    byte_valid = 1'b0;
    chk("t5_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_mem_we",  {31'd0, mem_we},  32'd0);
    chk("t5_rst_busy",    {31'd0, busy},    32'd0);
    chk("t5_rst_done",    {31'd0, done},    32'd0);
    chk("t5_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("t5_pending",     exp_q.size(),     32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_ram();
    data_b[0] = 8'hCA; data_b[1] = 8'hFE; data_b[2] = 8'hBA; data_b[3] = 8'hBE;
    begin_frame(1, 4, 1'b0, 2);
    send_byte(csum_of(4), 1'b0);
    wait_done(20, k);
    end_checks("t5", 1'b0, 1);
    chk("t5_ram0", dut_ram[0], 32'hCAFE_BABE);

    // 6: LEN=0 fills all 64 words; LEN=200 clamps to the same.
    for (int i = 0; i < 256; i++) data_b[i] = 8'(i);
    chk("t6_model_csum", {24'd0, csum_of(256)}, 32'h00);
    clear_ram();
    begin_frame(0, 256, 1'b0, -1);
    send_byte(csum_of(256), 1'b0);
    wait_done(20, k);
    end_checks("t6", 1'b0, 64);
    chk("t6_ram0",  dut_ram[0],  32'h0001_0203);
    chk("t6_ram63", dut_ram[63], 32'hFCFD_FEFF);
    clear_ram();
    begin_frame(200, 256, 1'b0, -1);
    send_byte(csum_of(256), 1'b0);
    wait_done(20, k);
    end_checks("t6_clamp", 1'b0, 64);
    chk("t6_clamp_ram63", dut_ram[63], 32'hFCFD_FEFF);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 2ms");
    $fatal(1, "simulation time limit");
  end

endmodule
